// File: rtl/upc_serial_tx_pkg.sv
// Shared types and framing constants for the UPC serial transmitter.
// Build option: UPC_PARITY_EN adds an even-parity bit after the data bits.
package upc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   UPC_W     = 3;
    localparam int   DATA_BITS = 4;
    localparam int   BIT_IDX_W = $clog2(DATA_BITS);
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic logic even_parity(input logic [UPC_W-1:0] i_upc, input logic i_mark);
        return ^{i_upc, i_mark};
    endfunction

endpackage

// File: rtl/upc_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while a frame runs and flags the
// last cycle of each bit. Restarted on frame accept. Build option: UPC_PARITY_EN (unused here).
module upc_bit_timer
    import upc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    input  logic i_run,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == LAST);
    assign o_tick = i_run && w_last;

    always_ff @(posedge clk) begin
        if (reset || i_restart || !i_run) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/upc_serial_tx.sv
// Scanner-side serial transmitter: frames {U,P,C,mark} as start/data/[parity]/stop.
// Build option: UPC_PARITY_EN includes the PARITY state; otherwise DATA goes straight to STOP.
module upc_serial_tx
    import upc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int COUNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [UPC_W-1:0]   upc,
    input  logic               mark,
    output logic               tx_serial,
    output logic               busy,
    output logic               frame_done,
    output logic [COUNT_W-1:0] items_sent
);

    tx_state_t              r_state;
    tx_state_t              w_next_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [BIT_IDX_W-1:0]   r_bit_idx;
    logic [COUNT_W-1:0]     r_items;
    logic                   w_accept;
    logic                   w_tick;
    logic                   w_last_data;
    logic                   w_tx;
`ifdef UPC_PARITY_EN
    logic                   r_parity;
`endif

    assign in_ready    = (r_state == IDLE);
    assign busy        = ~in_ready;
    assign w_accept    = in_ready && in_valid;
    assign w_last_data = (r_bit_idx == BIT_IDX_W'(DATA_BITS - 1));
    assign frame_done  = (r_state == STOP) && w_tick;
    assign tx_serial   = w_tx;
    assign items_sent  = r_items;

    upc_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .i_restart(w_accept),
        .i_run    (busy),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tx         = LINE_IDLE;
        case (r_state)
            IDLE: begin
                if (in_valid) w_next_state = START;
            end
            START: begin
                w_tx = START_BIT;
                if (w_tick) w_next_state = DATA;
            end
            DATA: begin
                w_tx = r_shift[DATA_BITS-1];
                if (w_tick && w_last_data) begin
`ifdef UPC_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = STOP;
`endif
                end
            end
`ifdef UPC_PARITY_EN
            PARITY: begin
                w_tx = r_parity;
                if (w_tick) w_next_state = STOP;
            end
`endif
            STOP: begin
                w_tx = STOP_BIT;
                if (w_tick) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Data is sent MSB first (U, P, C, mark); the shifter advances once per bit period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else if (w_accept) begin
            r_shift   <= {upc, mark};
            r_bit_idx <= '0;
        end else if ((r_state == DATA) && w_tick) begin
            r_shift   <= {r_shift[DATA_BITS-2:0], 1'b0};
            r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
        end
    end

`ifdef UPC_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= even_parity(upc, mark);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_items <= '0;
        end else if (frame_done) begin
            r_items <= r_items + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_upc_serial_tx.sv
// Scoreboard bench for upc_serial_tx: two instances (4 clk/bit 8-bit count, 1 clk/bit 2-bit count).
// Frame length follows UPC_PARITY_EN.
module tb_upc_serial_tx;

    localparam int CPB0 = 4;
    localparam int CW0  = 8;
    localparam int CPB1 = 1;
    localparam int CW1  = 2;
`ifdef UPC_PARITY_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    typedef struct {
        logic [6:0]  bits;
        int unsigned acc;
        logic [7:0]  cnt;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           vld    [2];
    logic [2:0]     upc_i  [2];
    logic           mark_i [2];
    logic           rdy    [2];
    logic           txs    [2];
    logic           bsy    [2];
    logic           dn     [2];
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  mdl_cnt [2];
    int          pend    [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    upc_serial_tx #(.CLKS_PER_BIT(CPB0), .COUNT_W(CW0)) dut0 (
        .clk(clk), .reset(rst), .in_valid(vld[0]), .in_ready(rdy[0]),
        .upc(upc_i[0]), .mark(mark_i[0]), .tx_serial(txs[0]), .busy(bsy[0]),
        .frame_done(dn[0]), .items_sent(cnt0)
    );

    upc_serial_tx #(.CLKS_PER_BIT(CPB1), .COUNT_W(CW1)) dut1 (
        .clk(clk), .reset(rst), .in_valid(vld[1]), .in_ready(rdy[1]),
        .upc(upc_i[1]), .mark(mark_i[1]), .tx_serial(txs[1]), .busy(bsy[1]),
        .frame_done(dn[1]), .items_sent(cnt1)
    );

    function automatic logic [7:0] cnt_of(input int d);
        return (d == 0) ? 8'(cnt0) : 8'(cnt1);
    endfunction

    function automatic int cpb_of(input int d);
        return (d == 0) ? CPB0 : CPB1;
    endfunction

    function automatic logic [7:0] next_count(input int d, input logic [7:0] c);
        int w;
        w = (d == 0) ? CW0 : CW1;
        return 8'((int'(c) + 1) % (1 << w));
    endfunction

    // Reference frame: start, U, P, C, mark, [even parity], stop.
    function automatic logic [6:0] frame_bits(input logic [2:0] u, input logic m);
        logic [6:0] b;
        b    = '0;
        b[0] = 1'b0;
        b[1] = u[2];
        b[2] = u[1];
        b[3] = u[0];
        b[4] = m;
        if (NB == 7) begin
            b[5] = ($countones({u, m}) % 2) == 1;
            b[6] = 1'b1;
        end else begin
            b[5] = 1'b1;
        end
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic send(input int d, input logic [2:0] u, input logic m);
        exp_t e;
        int   w;
        w         = 0;
        vld[d]    = 1'b1;
        upc_i[d]  = u;
        mark_i[d] = m;
        while (1) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) begin
                mdl_cnt[d] = next_count(d, mdl_cnt[d]);
                e.bits = frame_bits(u, m);
                e.acc  = cyc;
                e.cnt  = mdl_cnt[d];
                pend[d]++;
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            w++;
            if (w > 100) begin
                chk($sformatf("accept_timeout%0d", d), 0, 1);
                vld[d] = 1'b0;
                return;
            end
        end
    endtask

    task automatic monitor(input int d);
        exp_t e;
        int   cpb;
        bit   aborted;
        cpb = cpb_of(d);
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || txs[d] !== 1'b0) continue;
            if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                chk($sformatf("unexpected_start%0d", d), 1, 0);
                continue;
            end
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("start_latency%0d", d), cyc, e.acc + 1);
            aborted = 1'b0;
            for (int k = 0; k < NB * cpb; k++) begin
                if (k > 0) @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                chk($sformatf("tx_bit%0d_k%0d", d, k), txs[d], e.bits[k / cpb]);
                chk($sformatf("frame_done%0d_k%0d", d, k), dn[d], (k == NB * cpb - 1));
                chk($sformatf("busy%0d", d), bsy[d], 1);
            end
            if (!aborted) begin
                @(negedge clk);
                if (!rst) begin
                    chk($sformatf("ready_after_frame%0d", d), rdy[d], 1);
                    chk($sformatf("items_sent%0d", d), cnt_of(d), e.cnt);
                    chk($sformatf("line_after_frame%0d", d), txs[d], 1);
                    chk($sformatf("done_after_frame%0d", d), dn[d], 0);
                end
            end
            pend[d]--;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((pend[0] != 0 || pend[1] != 0) && w < 1000) begin
            @(posedge clk);
            w++;
        end
        chk("drain_timeout", (pend[0] != 0 || pend[1] != 0), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_driver(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            send(d, 3'($urandom), 1'($urandom));
            if (d == 0 && ($urandom % 2) == 1) begin
                // Frame is at least 24 cycles here, so these pulses stay inside busy.
                repeat (3) begin
                    upc_i[d]  = 3'($urandom);
                    mark_i[d] = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                vld[d] = 1'b0;
            end
            if (($urandom % 2) == 1) begin
                vld[d] = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        vld[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vld[d]     = 1'b0;
            upc_i[d]   = '0;
            mark_i[d]  = 1'b0;
            mdl_cnt[d] = '0;
            pend[d]    = 0;
        end
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_line%0d", d), txs[d], 1);
            chk($sformatf("reset_ready%0d", d), rdy[d], 1);
            chk($sformatf("reset_busy%0d", d), bsy[d], 0);
            chk($sformatf("reset_done%0d", d), dn[d], 0);
            chk($sformatf("reset_count%0d", d), cnt_of(d), 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(0, 3'b101, 1'b0);
        vld[0] = 1'b0;
        drain();
        chk("count_after_first", cnt_of(0), 1);

        send(0, 3'b011, 1'b1);
        vld[0] = 1'b0;
        drain();

        // Three items with in_valid held high, then junk while busy.
        send(0, 3'b010, 1'b1);
        send(0, 3'b111, 1'b0);
        send(0, 3'b000, 1'b1);
        repeat (3) begin
            upc_i[0]  = 3'($urandom);
            mark_i[0] = 1'($urandom);
            @(posedge clk);
            #1;
        end
        vld[0] = 1'b0;
        drain();
        chk("count_after_burst", cnt_of(0), 5);

        // Reset in the third data bit aborts the frame.
        send(0, 3'b110, 1'b1);
        vld[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_line", txs[0], 1);
        chk("abort_ready", rdy[0], 1);
        chk("abort_busy", bsy[0], 0);
        chk("abort_done", dn[0], 0);
        chk("abort_count", cnt_of(0), 0);
        rst = 1'b0;
        q0.delete();
        mdl_cnt[0] = '0;
        mdl_cnt[1] = '0;
        drain();

        for (int i = 0; i < 5; i++) send(1, 3'($urandom), 1'($urandom));
        vld[1] = 1'b0;
        drain();
        chk("wrap_count", cnt_of(1), 1);

        fork
            rand_driver(0, 20);
            rand_driver(1, 15);
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
